ctrl_hazard_pipe: RTL and testbench
===================================

// Module: ctrl_hazard_pipe
// PURPOSE
//  Parametrised ID->EX->MEM->WB control-signal pipeline with built-in hazard control.
//  Takes the decoded control bundle from the Control Unit and registers it through the EX, MEM and WB stages.
//  Inserts bubbles for load-use hazards and taken branches, and freezes on external memory stall.
//  Drives the load enables for PC and IF_ID. Keeps saturating stall/flush event counters.
//  Sits between Control_Unit and the datapath; replaces the fixed CU_mux and the ID_EX / EX_MEM / MEM_WB control regs.
// PARAMETERS
//  OP_W    4   opcode width carried to EX
//  CTRL_W  9   control bundle width; bit order fixed by the package constants
//  RA_W    4   register-address width (rn/rm/rd)
//  CNT_W   16  width of each event counter (saturating)
// PORTS
//  clk            in   1       rising-edge clock, the only clock
//  R              in   1       reset, synchronous, active-high
//  id_valid       in   1       ID stage holds a real instruction
//  id_opcode      in   OP_W    decoded opcode
//  id_ctrl        in   CTRL_W  decoded control bundle
//  id_rn, id_rm   in   RA_W    ID source registers
//  id_use_rn/rm   in   1       ID actually reads rn / rm
//  id_rd          in   RA_W    ID destination register
//  ex_br_taken    in   1       branch/BL resolved taken in EX
//  stall_ext      in   1       memory not ready; freeze whole pipe
//  pc_le, ifid_le out  1       load enables for PC and IF_ID (combinational)
//  ifid_flush     out  1       clear IF_ID on next edge (combinational)
//  ex_valid,mem_valid,wb_valid  out 1   stage valid bits
//  ex_opcode      out  OP_W    EX opcode
//  ex_ctrl,mem_ctrl,wb_ctrl     out CTRL_W  stage control bundles
//  ex_rd,mem_rd,wb_rd           out RA_W    stage destination registers
//  lu_stall       out  1       load-use hazard detected this cycle
//  stall_cnt      out  CNT_W   cycles with lu_stall or stall_ext
//  flush_cnt      out  CNT_W   cycles with an effective flush
// BEHAVIOUR
//  Reset (R=1 at edge): all valid bits, ctrl, opcode, rd and counters are 0. R overrides every other input.
//  Bubble: valid=0, opcode=0, ctrl=0, rd=0. A stage with valid=0 always presents ctrl=0.
//  Load-use, combinational: lu = ex_valid & ex_ctrl[LOAD] & ex_ctrl[RF_EN] & id_valid
//    & ((id_use_rn & id_rn==ex_rd) | (id_use_rm & id_rm==ex_rd)).
//  Flush, combinational: fl = ex_valid & ex_br_taken.
//  Per-edge priority, highest first: R > stall_ext > fl > lu > normal.
//   stall_ext: all stage regs hold; pc_le=ifid_le=0; ifid_flush=0; stall_cnt+1.
//   fl: EX<=bubble (ID squashed); MEM<=EX; WB<=MEM; pc_le=ifid_le=1; ifid_flush=1; flush_cnt+1.
//     lu in the same cycle is ignored and lu_stall=0.
//   lu: EX<=bubble; MEM<=EX; WB<=MEM; pc_le=ifid_le=0; lu_stall=1; stall_cnt+1.
//     Exactly one bubble per load-use: the next cycle the load is in MEM, so lu deasserts.
//   normal: EX<=ID (ctrl forced 0 if !id_valid); MEM<=EX; WB<=MEM; pc_le=ifid_le=1.
//  Latency: ID->EX 1 cycle, ->MEM 2, ->WB 3 in the absence of stalls.
//  Freeze persistence: ex_br_taken is sourced from EX, which is frozen during stall_ext, so fl recurs on release.
//  Counters saturate at all-ones and never wrap. Both increment in the same cycle only if the priority rules allow it; they do not.
//  Reset mid-stall: the next cycle starts with empty stages; pc_le=1 unless stall_ext.
//  Combinational outputs are defined during R using the current register values.
// STRUCTURE
//  Package ctrl_pkg:
//   - bundle bit constants: AM=0, S_EN=1, LOAD=2, RF_EN=3, SIZE=4, RW=5, EN=6, BL=7, B=8
//   - CTRL_W default
//  Sub-module ctrl_stage_reg: one stage register holding {valid, opcode, ctrl, rd}.
//   - inputs hold and bubble; hold wins over bubble; sync reset R
//   - instantiated three times (EX, MEM, WB)
//  Hazard/priority logic and counters live in the top.
// TESTING
//  1. Reset: R=1 for 2 edges with arbitrary inputs -> all valids/ctrl/counters 0, pc_le=1.
//  2. Straight flow: ID ctrl=9'h008 (RF_EN), rd=3 for 1 cycle -> ex_ctrl=008 at +1, mem at +2, wb at +3; no stalls.
//  3. Load-use: EX ctrl=9'h00C, rd=5; ID rn=5, use_rn=1 -> lu_stall=1, pc_le=0, next EX bubble.
//     Following cycle lu_stall=0 and the ID instruction enters EX; stall_cnt=1.
//  4. Branch+load-use same cycle: ex_br_taken=1 with lu true -> ifid_flush=1, lu_stall=0, EX bubble, flush_cnt=1, stall_cnt=0.
//  5. stall_ext=1 for 3 cycles mid-stream -> all stage regs unchanged, pc_le=0, stall_cnt+=3; resumes exactly on release.
//  6. Saturation with CNT_W=2: hold stall_ext 6 cycles -> stall_cnt stays 3. Then R mid-stall -> all 0 next cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the ID->EX->MEM->WB control pipeline: bundle bit
// positions and the default bundle width.
package ctrl_pkg;

  localparam int CTRL_W_DEF = 9;

  localparam int AM    = 0;
  localparam int S_EN  = 1;
  localparam int LOAD  = 2;
  localparam int RF_EN = 3;
  localparam int SIZE  = 4;
  localparam int RW    = 5;
  localparam int EN    = 6;
  localparam int BL    = 7;
  localparam int B     = 8;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register carrying {valid, opcode, ctrl, rd}.
// Hold freezes the stage and wins over bubble; an invalid input loads as a bubble.
module ctrl_stage_reg #(
  parameter int OP_W   = 4,
  parameter int CTRL_W = 9,
  parameter int RA_W   = 4
) (
  input  logic              clk,
  input  logic              R,
  input  logic              hold,
  input  logic              bubble,
  input  logic              nxt_valid,
  input  logic [OP_W-1:0]   nxt_opcode,
  input  logic [CTRL_W-1:0] nxt_ctrl,
  input  logic [RA_W-1:0]   nxt_rd,
  output logic              valid,
  output logic [OP_W-1:0]   opcode,
  output logic [CTRL_W-1:0] ctrl,
  output logic [RA_W-1:0]   rd
);

  always_ff @(posedge clk) begin
    if (R) begin
      valid  <= 1'b0;
      opcode <= '0;
      ctrl   <= '0;
      rd     <= '0;
    end else if (hold) begin
      valid  <= valid;
      opcode <= opcode;
      ctrl   <= ctrl;
      rd     <= rd;
    end else if (bubble || !nxt_valid) begin
      // an empty slot never presents stale control bits downstream
      valid  <= 1'b0;
      opcode <= '0;
      ctrl   <= '0;
      rd     <= '0;
    end else begin
      valid  <= 1'b1;
      opcode <= nxt_opcode;
      ctrl   <= nxt_ctrl;
      rd     <= nxt_rd;
    end
  end

endmodule

// File: rtl/ctrl_hazard_pipe.sv
// Control-bundle pipeline ID->EX->MEM->WB with load-use bubbling, branch flush,
// external-stall freeze, PC/IF_ID load enables and saturating event counters.
module ctrl_hazard_pipe
  import ctrl_pkg::*;
#(
  parameter int OP_W   = 4,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int RA_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              R,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_opcode,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [RA_W-1:0]   id_rn,
  input  logic [RA_W-1:0]   id_rm,
  input  logic              id_use_rn,
  input  logic              id_use_rm,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              ex_br_taken,
  input  logic              stall_ext,
  output logic              pc_le,
  output logic              ifid_le,
  output logic              ifid_flush,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic [OP_W-1:0]   ex_opcode,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [RA_W-1:0]   ex_rd,
  output logic [RA_W-1:0]   mem_rd,
  output logic [RA_W-1:0]   wb_rd,
  output logic              lu_stall,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}}))
      return v + CNT_W'(1);
    return v;
  endfunction

  logic            lu;
  logic            fl;
  logic            ex_bubble;
  logic            stall_inc;
  logic            flush_inc;
  logic [OP_W-1:0] mem_opcode;
  logic [OP_W-1:0] wb_opcode;
  logic            unused_wb_opcode;

  always_comb begin
    lu = ex_valid & ex_ctrl[LOAD] & ex_ctrl[RF_EN] & id_valid
       & ((id_use_rn & (id_rn == ex_rd)) | (id_use_rm & (id_rm == ex_rd)));
    fl = ex_valid & ex_br_taken;
    // a taken branch squashes ID anyway, so a coincident load-use is moot
    lu_stall   = lu & ~fl & ~stall_ext;
    ifid_flush = fl & ~stall_ext;
    pc_le      = ~stall_ext & (fl | ~lu);
    ifid_le    = pc_le;
    ex_bubble  = fl | lu;
    stall_inc  = stall_ext | lu_stall;
    flush_inc  = ifid_flush;
  end

  // ID -> EX
  ctrl_stage_reg #(.OP_W(OP_W), .CTRL_W(CTRL_W), .RA_W(RA_W)) u_ex (
    .clk        (clk),
    .R          (R),
    .hold       (stall_ext),
    .bubble     (ex_bubble),
    .nxt_valid  (id_valid),
    .nxt_opcode (id_opcode),
    .nxt_ctrl   (id_ctrl),
    .nxt_rd     (id_rd),
    .valid      (ex_valid),
    .opcode     (ex_opcode),
    .ctrl       (ex_ctrl),
    .rd         (ex_rd)
  );

  // EX -> MEM
  ctrl_stage_reg #(.OP_W(OP_W), .CTRL_W(CTRL_W), .RA_W(RA_W)) u_mem (
    .clk        (clk),
    .R          (R),
    .hold       (stall_ext),
    .bubble     (1'b0),
    .nxt_valid  (ex_valid),
    .nxt_opcode (ex_opcode),
    .nxt_ctrl   (ex_ctrl),
    .nxt_rd     (ex_rd),
    .valid      (mem_valid),
    .opcode     (mem_opcode),
    .ctrl       (mem_ctrl),
    .rd         (mem_rd)
  );

  // MEM -> WB
  ctrl_stage_reg #(.OP_W(OP_W), .CTRL_W(CTRL_W), .RA_W(RA_W)) u_wb (
    .clk        (clk),
    .R          (R),
    .hold       (stall_ext),
    .bubble     (1'b0),
    .nxt_valid  (mem_valid),
    .nxt_opcode (mem_opcode),
    .nxt_ctrl   (mem_ctrl),
    .nxt_rd     (mem_rd),
    .valid      (wb_valid),
    .opcode     (wb_opcode),
    .ctrl       (wb_ctrl),
    .rd         (wb_rd)
  );

  assign unused_wb_opcode = ^wb_opcode;

  always_ff @(posedge clk) begin
    if (R) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= sat_inc(stall_cnt, stall_inc);
      flush_cnt <= sat_inc(flush_cnt, flush_inc);
    end
  end

endmodule

// File: tb/tb_ctrl_hazard_pipe.sv
// Directed bench for ctrl_hazard_pipe: a default instance plus a CNT_W=2
// instance on the same inputs for counter saturation.
module tb_ctrl_hazard_pipe;

  logic       clk = 1'b0;
  logic       R;
  logic       id_valid;
  logic [3:0] id_opcode;
  logic [8:0] id_ctrl;
  logic [3:0] id_rn, id_rm, id_rd;
  logic       id_use_rn, id_use_rm;
  logic       ex_br_taken, stall_ext;

  logic        pc_le, ifid_le, ifid_flush, ex_valid, mem_valid, wb_valid, lu_stall;
  logic [3:0]  ex_opcode, ex_rd, mem_rd, wb_rd;
  logic [8:0]  ex_ctrl, mem_ctrl, wb_ctrl;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_le, s_ifid_le, s_ifid_flush, s_ex_valid, s_mem_valid, s_wb_valid, s_lu_stall;
  logic [3:0]  s_ex_opcode, s_ex_rd, s_mem_rd, s_wb_rd;
  logic [8:0]  s_ex_ctrl, s_mem_ctrl, s_wb_ctrl;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ctrl_hazard_pipe dut (
    .clk(clk), .R(R), .id_valid(id_valid), .id_opcode(id_opcode), .id_ctrl(id_ctrl),
    .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_rd(id_rd),
    .ex_br_taken(ex_br_taken), .stall_ext(stall_ext),
    .pc_le(pc_le), .ifid_le(ifid_le), .ifid_flush(ifid_flush),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .ex_opcode(ex_opcode), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .lu_stall(lu_stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  ctrl_hazard_pipe #(.CNT_W(2)) dut_sat (
    .clk(clk), .R(R), .id_valid(id_valid), .id_opcode(id_opcode), .id_ctrl(id_ctrl),
    .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_rd(id_rd),
    .ex_br_taken(ex_br_taken), .stall_ext(stall_ext),
    .pc_le(s_pc_le), .ifid_le(s_ifid_le), .ifid_flush(s_ifid_flush),
    .ex_valid(s_ex_valid), .mem_valid(s_mem_valid), .wb_valid(s_wb_valid),
    .ex_opcode(s_ex_opcode), .ex_ctrl(s_ex_ctrl), .mem_ctrl(s_mem_ctrl), .wb_ctrl(s_wb_ctrl),
    .ex_rd(s_ex_rd), .mem_rd(s_mem_rd), .wb_rd(s_wb_rd),
    .lu_stall(s_lu_stall), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_chk++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic id_idle();
    id_valid = 0; id_opcode = 0; id_ctrl = 0; id_rn = 0; id_rm = 0;
    id_use_rn = 0; id_use_rm = 0; id_rd = 0;
  endtask

  task automatic id_set(input logic [3:0] op, input logic [8:0] c, input logic [3:0] rd,
                        input logic [3:0] rn, input logic urn);
    id_valid = 1; id_opcode = op; id_ctrl = c; id_rd = rd;
    id_rn = rn; id_use_rn = urn; id_rm = 4'hF; id_use_rm = 0;
  endtask

  initial begin
    // 1. reset with arbitrary inputs
    R = 1; stall_ext = 0; ex_br_taken = 1;
    id_set(4'h7, 9'h1FF, 4'h9, 4'h9, 1'b1);
    tick(); tick();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_ex_ctrl", ex_ctrl, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_pc_le", pc_le, 1);
    R = 0; ex_br_taken = 0; id_idle();

    // 2. straight flow, latency 1/2/3
    id_set(4'hA, 9'h008, 4'h3, 4'h0, 1'b0);
    tick();
    id_idle(); settle();
    chk("flow_ex_ctrl", ex_ctrl, 9'h008);
    chk("flow_ex_rd", ex_rd, 3);
    chk("flow_ex_opcode", ex_opcode, 4'hA);
    chk("flow_lu", lu_stall, 0);
    tick();
    chk("flow_mem_ctrl", mem_ctrl, 9'h008);
    chk("flow_ex_empty", ex_ctrl, 0);
    tick();
    chk("flow_wb_ctrl", wb_ctrl, 9'h008);
    chk("flow_wb_rd", wb_rd, 3);
    chk("flow_stall_cnt", stall_cnt, 0);

    // 3. load-use gives exactly one bubble
    id_set(4'h2, 9'h00C, 4'h5, 4'h0, 1'b0);
    tick();
    id_set(4'h1, 9'h008, 4'h6, 4'h5, 1'b1); settle();
    chk("lu_stall", lu_stall, 1);
    chk("lu_pc_le", pc_le, 0);
    chk("lu_ifid_le", ifid_le, 0);
    tick();
    chk("lu_ex_bubble", ex_valid, 0);
    chk("lu_ex_ctrl0", ex_ctrl, 0);
    chk("lu_mem_load", mem_ctrl, 9'h00C);
    chk("lu_deassert", lu_stall, 0);
    chk("lu_pc_le_back", pc_le, 1);
    chk("lu_stall_cnt", stall_cnt, 1);
    tick();
    id_idle(); settle();
    chk("lu_ex_enters", ex_ctrl, 9'h008);
    chk("lu_ex_rd", ex_rd, 6);
    chk("lu_stall_cnt_hold", stall_cnt, 1);

    // 4. branch and load-use in the same cycle
    R = 1; tick(); R = 0;
    id_set(4'h2, 9'h00C, 4'h5, 4'h0, 1'b0);
    tick();
    id_set(4'h1, 9'h008, 4'h7, 4'h5, 1'b1); ex_br_taken = 1; settle();
    chk("br_flush", ifid_flush, 1);
    chk("br_lu_masked", lu_stall, 0);
    chk("br_pc_le", pc_le, 1);
    tick();
    ex_br_taken = 0; id_idle(); settle();
    chk("br_ex_bubble", ex_valid, 0);
    chk("br_mem_load", mem_ctrl, 9'h00C);
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt", stall_cnt, 0);

    // 5. external stall freezes the pipe for 3 cycles
    id_set(4'h3, 9'h008, 4'h1, 4'h0, 1'b0); tick();
    id_set(4'h3, 9'h008, 4'h2, 4'h0, 1'b0); tick();
    id_set(4'h3, 9'h008, 4'h3, 4'h0, 1'b0); stall_ext = 1; settle();
    chk("ext_pc_le", pc_le, 0);
    chk("ext_ifid_le", ifid_le, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("ext_ex_rd", ex_rd, 2);
      chk("ext_mem_rd", mem_rd, 1);
      chk("ext_wb_valid", wb_valid, 0);
      chk("ext_stall_cnt", stall_cnt, i);
    end
    chk("ext_flush_cnt", flush_cnt, 1);
    stall_ext = 0; settle();
    chk("ext_release_pc_le", pc_le, 1);
    tick();
    chk("ext_resume_ex", ex_rd, 3);
    chk("ext_resume_mem", mem_rd, 2);
    chk("ext_resume_wb", wb_rd, 1);
    chk("ext_resume_wbv", wb_valid, 1);
    chk("ext_sat_cnt3", s_stall_cnt, 3);

    // 6. saturation on the narrow instance, then reset mid-stall
    id_set(4'h3, 9'h008, 4'h4, 4'h0, 1'b0); tick();
    stall_ext = 1;
    for (int i = 0; i < 6; i++) tick();
    chk("sat_narrow", s_stall_cnt, 3);
    chk("sat_wide", stall_cnt, 9);
    chk("sat_ex_frozen", ex_rd, 4);
    R = 1; tick(); R = 0; settle();
    chk("rst_stall_ex_valid", ex_valid, 0);
    chk("rst_stall_mem_valid", mem_valid, 0);
    chk("rst_stall_wb_valid", wb_valid, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_stall_sat_cnt", s_stall_cnt, 0);
    chk("rst_stall_flush_cnt", flush_cnt, 0);
    chk("rst_stall_pc_le_ext", pc_le, 0);
    stall_ext = 0; id_idle(); settle();
    chk("rst_stall_pc_le", pc_le, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
